// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its storage array.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam int DMEM_WORD_W = 32;
   localparam int DMEM_BE_W   = 4;

   // Expands per-byte enables into a bit mask over the full word.
   function automatic logic [DMEM_WORD_W-1:0] be_mask(input logic [DMEM_BE_W-1:0] be);
      logic [DMEM_WORD_W-1:0] m;
      m = '0;
      for (int i = 0; i < DMEM_BE_W; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: one synchronous masked write port, one combinational read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64
) (
   input  logic                           clk,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
   input  logic [DMEM_WORD_W-1:0]         wr_data,
   input  logic [DMEM_WORD_W-1:0]         wr_mask,
   input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
   output logic [DMEM_WORD_W-1:0]         rd_data
);

   logic [DMEM_WORD_W-1:0] ram_memory [DEPTH_WORDS];

   // Contents survive reset on purpose, so no reset term here.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram_memory[wr_idx] <= (ram_memory[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   assign rd_data = ram_memory[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with LATENCY wait states in front of dmem_array.
// Optional DMEM_ERR_EN adds range/alignment fault reporting on resp_err.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [31:0]            req_addr,
   input  logic [DMEM_WORD_W-1:0] req_wdata,
   input  logic [DMEM_BE_W-1:0]   req_be,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [DMEM_WORD_W-1:0] resp_rdata,
   output logic                   resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_INIT = 4'(LATENCY);

   dmem_state_e            state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [31:0]            addr_q, addr_d;
   logic [DMEM_WORD_W-1:0] wdata_q, wdata_d;
   logic [DMEM_BE_W-1:0]   be_q, be_d;
   logic                   req_ready_q, req_ready_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [DMEM_WORD_W-1:0] resp_rdata_q, resp_rdata_d;
   logic                   resp_err_q, resp_err_d;

   logic                   mem_we;
   logic [AW-1:0]          word_idx;
   logic [DMEM_WORD_W-1:0] mem_rdata;
   logic                   access_err;

   assign word_idx = addr_q[AW+1:2];

`ifdef DMEM_ERR_EN
   always_comb begin
      access_err = (|addr_q[31:AW+2])
                 | ((be_q == 4'b1111) && (addr_q[1:0] != 2'b00))
                 | (((be_q == 4'b0011) || (be_q == 4'b1100)) && addr_q[0]);
   end
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_q[31:AW+2], addr_q[1:0]};
   assign access_err = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_we       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d        = req_we;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               be_d        = req_be;
               cnt_d       = LAT_INIT;
               req_ready_d = 1'b0;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            // Counter reaching zero marks the edge that commits the access.
            if (cnt_q == 4'd0) begin
               mem_we       = we_q && !access_err;
               resp_rdata_d = (we_q || access_err) ? '0 : mem_rdata;
               resp_err_d   = access_err;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_idx  (word_idx),
      .wr_data (wdata_q),
      .wr_mask (be_mask(be_q)),
      .rd_idx  (word_idx),
      .rd_data (mem_rdata)
   );

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_mem [DEPTH];

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic model_err(input logic [31:0] a, input logic [3:0] be);
`ifdef DMEM_ERR_EN
      if (a >= 32'(DEPTH * 4)) return 1'b1;
      if (be == 4'b1111 && a[1:0] != 2'b00) return 1'b1;
      if ((be == 4'b0011 || be == 4'b1100) && a[0]) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // One full transaction; optionally holds the response and offers a competing request meanwhile.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int hold, input bit poke,
                         output logic [31:0] rd, output logic er);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 40) begin
         check("req_ready_wait", 32'(req_ready), 32'd0);
         @(posedge clk); #1; n++;
      end
      check("latency_edges", 32'(n), 32'(LAT + 1));
      rd = resp_rdata;
      er = resp_err;
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd40;
            req_wdata = 32'hDEADBEEF; req_be = 4'hF;
         end
         @(posedge clk); #1;
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, rd);
         check("hold_err", 32'(resp_err), 32'(er));
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("post_hs_valid", 32'(resp_valid), 32'd0);
      check("post_hs_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                           input int hold);
      logic [31:0] rd;
      logic er, e;
      e = model_err(addr, be);
      access(1'b1, addr, wd, be, hold, 1'b0, rd, er);
      if (!e) exp_mem[widx(addr)] = merge(exp_mem[widx(addr)], wd, be);
      check("store_rdata", rd, 32'd0);
      check("store_err", 32'(er), 32'(e));
      check("store_mem", dut.u_array.ram_memory[widx(addr)], exp_mem[widx(addr)]);
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [3:0] be, input int hold,
                          input bit poke);
      logic [31:0] rd;
      logic er, e;
      e = model_err(addr, be);
      access(1'b0, addr, 32'd0, be, hold, poke, rd, er);
      check("load_rdata", rd, e ? 32'd0 : exp_mem[widx(addr)]);
      check("load_err", 32'(er), 32'(e));
   endtask

   initial begin
      logic [31:0] a, d;
      logic [3:0]  be;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_be = '0; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < DEPTH; i++) do_store(32'(i * 4), $urandom(), 4'hF, 0);

      // Store 5 to word 2, read it back.
      do_store(32'd8, 32'd5, 4'hF, 0);
      check("t1_word2", dut.u_array.ram_memory[2], 32'd5);
      do_load(32'd8, 4'hF, 0, 1'b0);

      // Stalled response with a competing request offered; address 40 must stay untouched.
      do_load(32'd8, 4'hF, 4, 1'b1);
      do_load(32'd40, 4'hF, 0, 1'b0);

      // Single-lane store into a known word.
      do_store(32'd0, 32'hAABBCCDD, 4'hF, 0);
      do_store(32'd0, 32'h11223344, 4'b0100, 1);
      check("t4_word0", dut.u_array.ram_memory[0], 32'hAA22CCDD);
      do_store(32'd20, 32'h12345678, 4'b0000, 0);

      // Reset during the wait phase of a store to word 3.
      n_cmp = n_cmp;
      while (!req_ready) begin @(posedge clk); #1; end
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd12; req_wdata = ~exp_mem[3]; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t5_req_ready", 32'(req_ready), 32'd1);
      check("t5_resp_valid", 32'(resp_valid), 32'd0);
      check("t5_resp_rdata", resp_rdata, 32'd0);
      check("t5_resp_err", 32'(resp_err), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("t5_word3", dut.u_array.ram_memory[3], exp_mem[3]);
      @(posedge clk); #1;
      do_load(32'd12, 4'hF, 0, 1'b0);

`ifdef DMEM_ERR_EN
      do_load(32'd6, 4'hF, 0, 1'b0);
      d = exp_mem[0];
      do_store(32'd256, 32'hCAFEF00D, 4'hF, 0);
      check("t6_word0", dut.u_array.ram_memory[0], d);
`endif

      for (int k = 0; k < 60; k++) begin
         a  = $urandom();
         if ($urandom_range(0, 3) != 0) a = a % 32'(DEPTH * 4);
         be = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) do_store(a, $urandom(), be, $urandom_range(0, 3));
         else do_load(a, be, $urandom_range(0, 3), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
